// File: rtl/sr_simd_pkg.sv
// rtl/sr_simd_pkg.sv - shared op codes, FSM states and saturation limits for sr_simd_alu
package sr_simd_pkg;

  typedef enum logic [3:0] {
    ADD  = 4'd0,
    OR   = 4'd1,
    SRL  = 4'd2,
    SLTU = 4'd3,
    SUB  = 4'd4,
    KSLL = 4'd5,
    KADD = 4'd6,
    KSUB = 4'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Largest signed value of a w-bit lane, zero-extended to 64 bits.
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative signed value of a w-bit lane; only the low w bits are meaningful.
  function automatic logic [63:0] sat_min(input int w);
    return ~sat_max(w);
  endfunction

endpackage

// File: rtl/sr_simd_lane_step.sv
// rtl/sr_simd_lane_step.sv - one lane: saturating 1-bit left shift and saturating add/sub
module sr_simd_lane_step
  import sr_simd_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] shl,
  output logic         shl_sat,
  output logic [W-1:0] arith,
  output logic         arith_sat
);

  localparam logic [63:0] MAX64 = sat_max(W);
  localparam logic [63:0] MIN64 = sat_min(W);
  localparam logic [W-1:0] LANE_MAX = MAX64[W-1:0];
  localparam logic [W-1:0] LANE_MIN = MIN64[W-1:0];

  logic [W:0] ext;

  // A shift overflows when the two top bits differ; a saturated value re-saturates to itself.
  always_comb begin
    shl_sat   = a[W-1] ^ a[W-2];
    shl       = shl_sat ? (a[W-1] ? LANE_MIN : LANE_MAX) : {a[W-2:0], 1'b0};
    ext       = sub ? ({a[W-1], a} - {b[W-1], b}) : ({a[W-1], a} + {b[W-1], b});
    arith_sat = ext[W] ^ ext[W-1];
    arith     = arith_sat ? (ext[W] ? LANE_MIN : LANE_MAX) : ext[W-1:0];
  end

endmodule

// File: rtl/sr_simd_alu.sv
// rtl/sr_simd_alu.sv - scalar + packed-SIMD saturating execute unit with iterative KSLL
module sr_simd_alu
  import sr_simd_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int LANE_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  input  logic [3:0]      oper,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            ov,
  input  logic            sat_clr,
  output logic            sat_sticky
);

  localparam int LANES = XLEN / LANE_W;
  localparam int SA_W  = $clog2(LANE_W);
  localparam int XSA_W = $clog2(XLEN);

  state_t            state;
  logic [XLEN-1:0]   res_q;
  logic              ov_q;
  logic [SA_W-1:0]   cnt;
  logic              sticky_q;

  alu_op_t           op;
  logic [SA_W-1:0]   sa;
  logic              is_sub;
  logic [XLEN-1:0]   lane_a;
  logic [XLEN-1:0]   shl_v;
  logic [XLEN-1:0]   arith_v;
  logic [LANES-1:0]  shl_sat_v;
  logic [LANES-1:0]  arith_sat_v;
  logic [XLEN-1:0]   res_d;
  logic              ov_d;
  logic              handshake;

  assign op       = alu_op_t'(oper);
  assign sa       = srcB[SA_W-1:0];
  assign is_sub   = (op == KSUB);
  // While shifting, the lanes iterate on the partial result; otherwise they see the operand.
  assign lane_a   = (state == SHIFT) ? res_q : srcA;

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign result     = res_q;
  assign ov         = ov_q;
  assign zero       = (res_q == '0);
  assign sat_sticky = sticky_q;
  assign handshake  = (state == DONE) && out_ready && !flush;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    sr_simd_lane_step #(.W(LANE_W)) u_step (
      .a         (lane_a[l*LANE_W +: LANE_W]),
      .b         (srcB[l*LANE_W +: LANE_W]),
      .sub       (is_sub),
      .shl       (shl_v[l*LANE_W +: LANE_W]),
      .shl_sat   (shl_sat_v[l]),
      .arith     (arith_v[l*LANE_W +: LANE_W]),
      .arith_sat (arith_sat_v[l])
    );
  end

  // Single-cycle result for everything except the iterated KSLL steps.
  always_comb begin
    res_d = srcA + srcB;
    ov_d  = 1'b0;
    case (op)
      OR:   res_d = srcA | srcB;
      SRL:  res_d = srcA >> srcB[XSA_W-1:0];
      SLTU: res_d = {{(XLEN-1){1'b0}}, (srcA < srcB)};
      SUB:  res_d = srcA - srcB;
      KSLL: res_d = srcA;
      KADD, KSUB: begin
        res_d = arith_v;
        ov_d  = |arith_sat_v;
      end
      default: res_d = srcA + srcB;
    endcase
  end

  // Control FSM, result/ov registers, shift counter and sticky saturation flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      res_q    <= '0;
      ov_q     <= 1'b0;
      cnt      <= '0;
      sticky_q <= 1'b0;
    end else begin
      // Set wins over clear when both land on the same edge.
      sticky_q <= (sticky_q & ~sat_clr) | (handshake & ov_q);
      if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (in_valid) begin
              res_q <= res_d;
              ov_q  <= ov_d;
              cnt   <= sa;
              state <= (op == KSLL && sa != '0) ? SHIFT : DONE;
            end
          end
          SHIFT: begin
            res_q <= shl_v;
            ov_q  <= ov_q | (|shl_sat_v);
            cnt   <= cnt - SA_W'(1);
            if (cnt == SA_W'(1)) state <= DONE;
          end
          DONE: begin
            if (out_ready) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sr_simd_alu.sv
// tb/tb_sr_simd_alu.sv - scoreboard bench for sr_simd_alu at LANE_W=8 and LANE_W=16
module tb_sr_simd_alu;
  import sr_simd_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, flush, iv8, iv16, out_ready, sat_clr;
  logic [31:0] srcA, srcB;
  logic [3:0]  oper;

  logic        ir8, vd8, z8, ov8, st8;
  logic [31:0] res8;
  logic        ir16, vd16, z16, ov16, st16;
  logic [31:0] res16;

  typedef struct {
    logic [31:0] r;
    logic        o;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sr_simd_alu #(.XLEN(32), .LANE_W(8)) u8 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv8), .in_ready(ir8),
    .srcA(srcA), .srcB(srcB), .oper(oper), .out_valid(vd8), .out_ready(out_ready),
    .result(res8), .zero(z8), .ov(ov8), .sat_clr(sat_clr), .sat_sticky(st8)
  );

  sr_simd_alu #(.XLEN(32), .LANE_W(16)) u16 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv16), .in_ready(ir16),
    .srcA(srcA), .srcB(srcB), .oper(oper), .out_valid(vd16), .out_ready(out_ready),
    .result(res16), .zero(z16), .ov(ov16), .sat_clr(sat_clr), .sat_sticky(st16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: lane ops computed in wide signed arithmetic, KSLL as one multiply by 2^sa.
  function automatic void model(input int lw, input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] r, output logic o);
    longint      half, la, lb, v;
    int          sa;
    logic [31:0] m;
    r    = '0;
    o    = 1'b0;
    half = longint'(1) << (lw - 1);
    sa   = int'(b[4:0]) & (lw - 1);
    m    = (32'd1 << lw) - 32'd1;
    if (lw == 32) m = 32'hFFFF_FFFF;
    case (op)
      4'd1: r = a | b;
      4'd2: r = a >> b[4:0];
      4'd3: r = (a < b) ? 32'd1 : 32'd0;
      4'd4: r = a - b;
      4'd5, 4'd6, 4'd7: begin
        for (int l = 0; l < 32 / lw; l++) begin
          la = longint'((a >> (l * lw)) & m);
          lb = longint'((b >> (l * lw)) & m);
          if (la >= half) la -= 2 * half;
          if (lb >= half) lb -= 2 * half;
          if (op == 4'd5)      v = la * (longint'(1) << sa);
          else if (op == 4'd6) v = la + lb;
          else                 v = la - lb;
          if (v > half - 1) begin v = half - 1; o = 1'b1; end
          else if (v < -half) begin v = -half; o = 1'b1; end
          r |= (32'(v) & m) << (l * lw);
        end
      end
      default: r = a + b;
    endcase
  endfunction

  // Issue one op, wait for its result, compare with the scoreboard head, then hand it off.
  task automatic do_op(input bit s16, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int hold, input bit clr, input string tag);
    exp_t e;
    int   lat, lw;
    lw = s16 ? 16 : 8;
    model(lw, op, a, b, e.r, e.o);
    e.lat = (op == 4'd5) ? (int'(b[4:0]) & (lw - 1)) : 0;
    sb.push_back(e);
    chk({tag, "_in_ready"}, {31'b0, s16 ? ir16 : ir8}, 32'd1);
    oper = op; srcA = a; srcB = b; out_ready = (hold == 0);
    if (s16) iv16 = 1'b1; else iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0; iv16 = 1'b0;
    lat = 0;
    while (!(s16 ? vd16 : vd8) && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    e = sb.pop_front();
    chk({tag, "_latency"}, 32'(lat), 32'(e.lat));
    chk({tag, "_result"}, s16 ? res16 : res8, e.r);
    chk({tag, "_ov"}, {31'b0, s16 ? ov16 : ov8}, {31'b0, e.o});
    chk({tag, "_zero"}, {31'b0, s16 ? z16 : z8}, {31'b0, e.r == 32'd0});
    for (int h = 0; h < hold; h++) begin
      oper = 4'd0; srcA = 32'd1; srcB = 32'd1;
      if (s16) iv16 = 1'b1; else iv8 = 1'b1;
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, {31'b0, s16 ? vd16 : vd8}, 32'd1);
      chk({tag, "_hold_result"}, s16 ? res16 : res8, e.r);
      chk({tag, "_hold_zero"}, {31'b0, s16 ? z16 : z8}, {31'b0, e.r == 32'd0});
      chk({tag, "_hold_in_ready"}, {31'b0, s16 ? ir16 : ir8}, 32'd0);
    end
    iv8 = 1'b0; iv16 = 1'b0;
    out_ready = 1'b1;
    sat_clr = clr;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    chk({tag, "_after_valid"}, {31'b0, s16 ? vd16 : vd8}, 32'd0);
  endtask

  task automatic clr_pulse();
    sat_clr = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0; flush = 1'b0; iv8 = 1'b0; iv16 = 1'b0; out_ready = 1'b0; sat_clr = 1'b0;
    srcA = '0; srcB = '0; oper = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'b0, ir8}, 32'd1);
    chk("rst_out_valid", {31'b0, vd8}, 32'd0);
    chk("rst_result", res8, 32'd0);
    chk("rst_ov", {31'b0, ov8}, 32'd0);
    chk("rst_zero", {31'b0, z8}, 32'd1);
    chk("rst_sticky", {31'b0, st8}, 32'd0);
    chk("rst_in_ready16", {31'b0, ir16}, 32'd1);
    rst_n = 1'b1;

    do_op(1'b0, KSLL, 32'h7F01_C080, 32'd1, 0, 1'b0, "ksll_sa1");
    chk("ksll_sa1_sticky", {31'b0, st8}, 32'd1);
    do_op(1'b0, KSLL, 32'h0FF0_0801, 32'd3, 0, 1'b0, "ksll_sa3");
    do_op(1'b0, KSLL, 32'h0FF0_0801, 32'd0, 0, 1'b0, "ksll_sa0");
    clr_pulse();
    chk("clr_sticky0", {31'b0, st8}, 32'd0);

    do_op(1'b0, KADD, 32'h7F80_0102, 32'h01FF_0102, 0, 1'b0, "kadd");
    chk("kadd_sticky", {31'b0, st8}, 32'd1);
    clr_pulse();
    chk("kadd_clr", {31'b0, st8}, 32'd0);
    do_op(1'b0, KADD, 32'h7F80_0102, 32'h01FF_0102, 0, 1'b1, "kadd_clr_hs");
    chk("kadd_set_wins", {31'b0, st8}, 32'd1);
    do_op(1'b0, KSUB, 32'h8000_7F05, 32'h0101_FF03, 0, 1'b0, "ksub");

    do_op(1'b0, ADD, 32'hFFFF_FFFF, 32'd1, 5, 1'b0, "bp_add");
    chk("bp_idle_after", {31'b0, ir8}, 32'd1);

    clr_pulse();
    oper = KSLL; srcA = 32'h4040_4040; srcB = 32'd7; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    chk("flush_busy", {31'b0, ir8}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_in_ready", {31'b0, ir8}, 32'd1);
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      seen |= vd8;
    end
    chk("flush_no_valid", {31'b0, seen}, 32'd0);
    chk("flush_sticky", {31'b0, st8}, 32'd0);
    oper = ADD; srcA = 32'd5; srcB = 32'd6; iv8 = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0; flush = 1'b0;
    chk("flush_idle_noacc", {31'b0, vd8}, 32'd0);
    chk("flush_idle_ready", {31'b0, ir8}, 32'd1);

    do_op(1'b0, KADD, 32'h7F00_0000, 32'h0100_0000, 0, 1'b0, "pre_rst");
    chk("pre_rst_sticky", {31'b0, st8}, 32'd1);
    oper = KSLL; srcA = 32'h0102_0304; srcB = 32'd7; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mrst_in_ready", {31'b0, ir8}, 32'd1);
    chk("mrst_out_valid", {31'b0, vd8}, 32'd0);
    chk("mrst_result", res8, 32'd0);
    chk("mrst_ov", {31'b0, ov8}, 32'd0);
    chk("mrst_zero", {31'b0, z8}, 32'd1);
    chk("mrst_sticky", {31'b0, st8}, 32'd0);

    do_op(1'b1, KSLL, 32'h4000_FFFF, 32'd1, 0, 1'b0, "w16_ksll");
    do_op(1'b1, KSLL, 32'h0003_FFF0, 32'd13, 0, 1'b0, "w16_ksll13");
    do_op(1'b1, KADD, 32'h7FFF_0001, 32'h0001_0001, 0, 1'b0, "w16_kadd");

    for (int i = 0; i < 1000; i++) begin
      logic [3:0] rop;
      rop = 4'($urandom_range(0, 15));
      if (i % 4 == 0) rop = 4'($urandom_range(0, 4));
      do_op(1'(i % 2), rop, $urandom, $urandom, 0, 1'b0, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
